scara_step_driver: RTL and testbench



---
 rtl/scara_step_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_scara_step_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scara_step_driver.sv
// Step/direction pulse generator for the two SCARA joints: tracks absolute positions and
// walks both axes toward a latched target pair. Optional target clamping: SCARA_STEP_LIMIT_EN.
module scara_step_driver #(
  parameter int STEP_W    = 14,
  parameter int CLK_DIV   = 5000,
  parameter int PULSE_W   = 100,
  parameter int DIR_SETUP = 50
`ifdef SCARA_STEP_LIMIT_EN
  ,
  parameter int TH_MIN    = -4096,
  parameter int TH_MAX    = 4095
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [STEP_W-1:0] th1_steps,
  input  logic signed [STEP_W-1:0] th2_steps,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     enable,
  output logic                     th1_step,
  output logic                     th1_dir,
  output logic                     th2_step,
  output logic                     th2_dir,
  output logic signed [STEP_W-1:0] th1_pos,
  output logic signed [STEP_W-1:0] th2_pos,
  output logic                     busy,
  output logic                     done,
  output logic                     limit_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIR_SET = 3'd1,
    STEP_HI = 3'd2,
    STEP_LO = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(CLK_DIV + DIR_SETUP + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIR_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(CLK_DIV - PULSE_W - 1);
  localparam logic signed [STEP_W-1:0] POS_ONE  = STEP_W'(1);
  localparam logic signed [STEP_W-1:0] POS_ZERO = STEP_W'(0);

`ifdef SCARA_STEP_LIMIT_EN
  localparam logic signed [STEP_W-1:0] TH_MIN_S = STEP_W'(TH_MIN);
  localparam logic signed [STEP_W-1:0] TH_MAX_S = STEP_W'(TH_MAX);

  function automatic logic signed [STEP_W-1:0] clamp_target(input logic signed [STEP_W-1:0] t);
    if (t < TH_MIN_S) begin
      clamp_target = TH_MIN_S;
    end else if (t > TH_MAX_S) begin
      clamp_target = TH_MAX_S;
    end else begin
      clamp_target = t;
    end
  endfunction
`endif

  state_t                     state_r, state_s;
  logic [CNT_W-1:0]           cnt_r, cnt_s;
  logic signed [STEP_W-1:0]   pos1_r, pos2_r, pos1_s, pos2_s;
  logic signed [STEP_W-1:0]   tgt1_r, tgt2_r, tgt1_s, tgt2_s;
  logic signed [STEP_W-1:0]   cmd1_s, cmd2_s, nxt1_s, nxt2_s;
  logic                       dir1_r, dir2_r, dir1_s, dir2_s;
  logic                       step1_r, step2_r, step1_s, step2_s;
  logic                       busy_r, done_r, ready_r, lim_r, lim_s;
  logic                       clamp_s, fire_s, hi_end_s, adv1_s, adv2_s, at_tgt_s;

  // Condition the incoming target pair before it is latched.
  always_comb begin
`ifdef SCARA_STEP_LIMIT_EN
    cmd1_s  = clamp_target(th1_steps);
    cmd2_s  = clamp_target(th2_steps);
    clamp_s = (cmd1_s != th1_steps) || (cmd2_s != th2_steps);
`else
    cmd1_s  = th1_steps;
    cmd2_s  = th2_steps;
    clamp_s = 1'b0;
`endif
  end

  // Next-state and next-register logic; fire_s marks a step edge for every unfinished axis.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    tgt1_s   = tgt1_r;
    tgt2_s   = tgt2_r;
    dir1_s   = dir1_r;
    dir2_s   = dir2_r;
    lim_s    = lim_r;
    fire_s   = 1'b0;
    hi_end_s = 1'b0;
    adv1_s   = (pos1_r != tgt1_r);
    adv2_s   = (pos2_r != tgt2_r);
    at_tgt_s = !adv1_s && !adv2_s;
    nxt1_s   = dir1_r ? (pos1_r + POS_ONE) : (pos1_r - POS_ONE);
    nxt2_s   = dir2_r ? (pos2_r + POS_ONE) : (pos2_r - POS_ONE);
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (cmd_valid) begin
          tgt1_s = cmd1_s;
          tgt2_s = cmd2_s;
          lim_s  = clamp_s;
          if (cmd1_s != pos1_r) begin
            dir1_s = (cmd1_s > pos1_r);
          end else begin
            dir1_s = dir1_r;
          end
          if (cmd2_s != pos2_r) begin
            dir2_s = (cmd2_s > pos2_r);
          end else begin
            dir2_s = dir2_r;
          end
          if ((cmd1_s == pos1_r) && (cmd2_s == pos2_r)) begin
            state_s = DONE;
          end else begin
            state_s = DIR_SET;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DIR_SET: begin
        if (cnt_r == DIR_LAST) begin
          fire_s  = 1'b1;
          state_s = STEP_HI;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STEP_HI: begin
        if (cnt_r == HI_LAST) begin
          hi_end_s = 1'b1;
          state_s  = STEP_LO;
          cnt_s    = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STEP_LO: begin
        // The counter parks on its last value while a pause holds the next pulse back.
        if (cnt_r == LO_LAST) begin
          if (at_tgt_s) begin
            state_s = DONE;
          end else if (enable) begin
            fire_s  = 1'b1;
            state_s = STEP_HI;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    pos1_s  = (fire_s && adv1_s) ? nxt1_s : pos1_r;
    pos2_s  = (fire_s && adv2_s) ? nxt2_s : pos2_r;
    step1_s = fire_s ? adv1_s : (hi_end_s ? 1'b0 : step1_r);
    step2_s = fire_s ? adv2_s : (hi_end_s ? 1'b0 : step2_r);
  end

  // State, position and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      pos1_r  <= POS_ZERO;
      pos2_r  <= POS_ZERO;
      tgt1_r  <= POS_ZERO;
      tgt2_r  <= POS_ZERO;
      dir1_r  <= 1'b0;
      dir2_r  <= 1'b0;
      step1_r <= 1'b0;
      step2_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      lim_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pos1_r  <= pos1_s;
      pos2_r  <= pos2_s;
      tgt1_r  <= tgt1_s;
      tgt2_r  <= tgt2_s;
      dir1_r  <= dir1_s;
      dir2_r  <= dir2_s;
      step1_r <= step1_s;
      step2_r <= step2_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      ready_r <= (state_s == IDLE);
      lim_r   <= lim_s;
    end
  end

  assign cmd_ready = ready_r;
  assign th1_step  = step1_r;
  assign th2_step  = step2_r;
  assign th1_dir   = dir1_r;
  assign th2_dir   = dir2_r;
  assign th1_pos   = pos1_r;
  assign th2_pos   = pos2_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign limit_err = lim_r;

endmodule

// File: tb/tb_scara_step_driver.sv
// Bench for scara_step_driver: a cycle-schedule model checked every cycle, plus directed
// literal checks of pulse counts, widths, latencies and busy time.
module tb_scara_step_driver;
  localparam int CD = 10;
  localparam int PW = 3;
  localparam int DS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] th1_steps = 14'd0;
  logic [13:0] th2_steps = 14'd0;
  logic        cmd_valid = 1'b0;
  logic        enable = 1'b1;
  logic        cmd_ready, th1_step, th1_dir, th2_step, th2_dir, busy, done, limit_err;
  logic [13:0] th1_pos, th2_pos;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  scara_step_driver #(.STEP_W(14), .CLK_DIV(CD), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .reset_n(reset_n), .th1_steps(th1_steps), .th2_steps(th2_steps),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .enable(enable),
    .th1_step(th1_step), .th1_dir(th1_dir), .th2_step(th2_step), .th2_dir(th2_dir),
    .th1_pos(th1_pos), .th2_pos(th2_pos), .busy(busy), .done(done), .limit_err(limit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: absolute-time pulse schedule derived from the accept edge and sampled enable.
  int  m_t = 0, m_next = 0, m_off = -1;
  bit  m_busy = 0, m_fin = 0, m_first = 0, m_done = 0, m_lim = 0;
  bit  m_step1 = 0, m_step2 = 0, m_dir1 = 0, m_dir2 = 0;
  logic signed [13:0] m_pos1 = 14'sd0, m_pos2 = 14'sd0, m_tgt1 = 14'sd0, m_tgt2 = 14'sd0;
  logic signed [13:0] c1, c2;

  function automatic logic signed [13:0] m_cond(input logic signed [13:0] t);
`ifdef SCARA_STEP_LIMIT_EN
    if (t < -14'sd4096) return -14'sd4096;
    if (t > 14'sd4095) return 14'sd4095;
`endif
    return t;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_fin = 0; m_first = 0; m_done = 0; m_lim = 0; m_off = -1;
      m_step1 = 0; m_step2 = 0; m_dir1 = 0; m_dir2 = 0;
      m_pos1 = 0; m_pos2 = 0; m_tgt1 = 0; m_tgt2 = 0;
    end else begin
      m_t++;
      m_done = 0;
      if (m_t == m_off) begin m_step1 = 0; m_step2 = 0; end
      if (!m_busy) begin
        if (cmd_valid) begin
          c1 = m_cond($signed(th1_steps));
          c2 = m_cond($signed(th2_steps));
          m_lim = (c1 != $signed(th1_steps)) || (c2 != $signed(th2_steps));
          m_tgt1 = c1; m_tgt2 = c2;
          if (c1 > m_pos1) m_dir1 = 1; else if (c1 < m_pos1) m_dir1 = 0;
          if (c2 > m_pos2) m_dir2 = 1; else if (c2 < m_pos2) m_dir2 = 0;
          m_busy = 1;
          if (c1 == m_pos1 && c2 == m_pos2) begin m_done = 1; m_fin = 1; end
          else begin m_next = m_t + DS; m_first = 1; end
        end
      end else if (m_fin) begin
        m_busy = 0; m_fin = 0;
      end else if (m_t >= m_next) begin
        if (m_pos1 == m_tgt1 && m_pos2 == m_tgt2) begin
          m_done = 1; m_fin = 1;
        end else if (m_first || enable) begin
          m_step1 = (m_pos1 != m_tgt1);
          m_step2 = (m_pos2 != m_tgt2);
          if (m_step1) m_pos1 = m_dir1 ? m_pos1 + 1 : m_pos1 - 1;
          if (m_step2) m_pos2 = m_dir2 ? m_pos2 + 1 : m_pos2 - 1;
          m_first = 0; m_off = m_t + PW; m_next = m_t + CD;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("step1", th1_step, m_step1);
      chk("step2", th2_step, m_step2);
      chk("dir1", th1_dir, m_dir1);
      chk("dir2", th2_dir, m_dir2);
      chk("pos1", th1_pos, $unsigned(m_pos1));
      chk("pos2", th2_pos, $unsigned(m_pos2));
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("ready", cmd_ready, !m_busy);
      chk("limit", limit_err, m_lim);
    end
  end

  // Monitor: running pulse/busy statistics that directed checks difference.
  int cyc = 0, rises1 = 0, rises2 = 0, high1 = 0, high2 = 0, busy_cyc = 0, done_cyc = 0;
  int paused_rises = 0, busy_rise = 0, first_dly = -1;
  bit en_at_edge = 1, p1 = 0, p2 = 0, pb = 0, pend = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    en_at_edge <= enable;
  end

  always @(negedge clk) begin
    if (busy && !pb) begin busy_rise = cyc; pend = 1; end
    if (th1_step && !p1) begin
      rises1++;
      if (!en_at_edge) paused_rises++;
      if (pend) begin first_dly = cyc - busy_rise; pend = 0; end
    end
    if (th2_step && !p2) begin
      rises2++;
      if (!en_at_edge) paused_rises++;
    end
    if (th1_step) high1++;
    if (th2_step) high2++;
    if (busy) busy_cyc++;
    if (done) done_cyc++;
    p1 = th1_step; p2 = th2_step; pb = busy;
  end

  task automatic issue(input logic [13:0] a, input logic [13:0] b);
    @(negedge clk);
    th1_steps = a; th2_steps = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s_r1, s_r2, s_h1, s_h2, s_b, s_d, s_p;
    int k, n;
    logic pv;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_step1", th1_step, 1'b0);
    chk("rst_dir1", th1_dir, 1'b0);
    chk("rst_pos1", th1_pos, 14'd0);
    chk("rst_pos2", th2_pos, 14'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    // Move (3,-2) with a rejected command injected mid-move.
    s_r1 = rises1; s_r2 = rises2; s_h1 = high1; s_h2 = high2; s_b = busy_cyc; s_d = done_cyc;
    issue(14'd3, 14'h3FFE);
    chk("t2_dir1", th1_dir, 1'b1);
    chk("t2_dir2", th2_dir, 1'b0);
    repeat (8) @(negedge clk);
    th1_steps = 14'd100; th2_steps = 14'd100; cmd_valid = 1'b1;
    chk("t4_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("t2_timeout", 200);
    chk("t2_pos1", th1_pos, 14'd3);
    chk("t2_pos2", th2_pos, 14'h3FFE);
    chk("t2_pulses1", rises1 - s_r1, 32'd3);
    chk("t2_pulses2", rises2 - s_r2, 32'd2);
    chk("t2_high1", high1 - s_h1, 32'd9);
    chk("t2_high2", high2 - s_h2, 32'd6);
    chk("t2_busy_cycles", busy_cyc - s_b, 32'd33);
    chk("t2_done_cycles", done_cyc - s_d, 32'd1);
    chk("t2_first_step_delay", first_dly, 32'd2);

    // Null move.
    s_r1 = rises1; s_r2 = rises2;
    issue(14'd3, 14'h3FFE);
    chk("t3_done", done, 1'b1);
    chk("t3_busy", busy, 1'b1);
    chk("t3_dir1", th1_dir, 1'b1);
    chk("t3_dir2", th2_dir, 1'b0);
    @(negedge clk);
    chk("t3_done_end", done, 1'b0);
    chk("t3_idle", busy, 1'b0);
    chk("t3_no_pulses", (rises1 - s_r1) + (rises2 - s_r2), 32'd0);

    // Five-step move paused for 40 cycles after the second pulse.
    s_r1 = rises1; s_h1 = high1; s_b = busy_cyc; s_p = paused_rises;
    issue(14'd8, 14'h3FFE);
    k = 0; n = 0; pv = 1'b0;
    while (k < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (th1_step && !pv) k++;
      pv = th1_step;
    end
    chk("t5_second_pulse_seen", k, 32'd2);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    enable = 1'b1;
    wait_idle("t5_timeout", 300);
    chk("t5_pos1", th1_pos, 14'd8);
    chk("t5_pos2", th2_pos, 14'h3FFE);
    chk("t5_pulses1", rises1 - s_r1, 32'd5);
    chk("t5_high1", high1 - s_h1, 32'd15);
    chk("t5_busy_cycles", busy_cyc - s_b, 32'd84);
    chk("t5_paused_pulses", paused_rises - s_p, 32'd0);

`ifdef SCARA_STEP_LIMIT_EN
    issue(14'd5000, 14'h3FFE);
    chk("t6_limit_set", limit_err, 1'b1);
    wait_idle("t6_timeout", 45000);
    chk("t6_clamped_pos", th1_pos, 14'd4095);
    issue(14'd4090, 14'h3FFE);
    chk("t6_limit_clear", limit_err, 1'b0);
    wait_idle("t6b_timeout", 200);
    chk("t6b_pos", th1_pos, 14'd4090);
`endif

    // Asynchronous reset in the middle of a pulse.
    issue(14'h3F9C, 14'd100);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("ar_pre_step1", th1_step, 1'b1);
    chk("ar_pre_step2", th2_step, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_step1", th1_step, 1'b0);
    chk("ar_step2", th2_step, 1'b0);
    chk("ar_dir2", th2_dir, 1'b0);
    chk("ar_pos1", th1_pos, 14'd0);
    chk("ar_pos2", th2_pos, 14'd0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_ready", cmd_ready, 1'b1);
    chk("ar_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
